// File: rtl/spi_ram_ctrl.sv
// SPI-side RAM controller: decodes 10-bit frames into pointer/write/read
// commands and returns read data to the SPI slave for shifting out.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH   = 256,
    parameter int ADDR_SIZE   = 8,
    parameter int WR_AUTO_INC = 0,
    parameter int RD_AUTO_INC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        TX_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] CMD_WADDR = 2'b00;
    localparam logic [1:0] CMD_WDATA = 2'b01;
    localparam logic [1:0] CMD_RADDR = 2'b10;
    localparam logic [1:0] CMD_RDATA = 2'b11;

    state_t               state;
    state_t               state_nx;
    logic                 rx_valid_q;
    logic                 accept;
    logic                 exec;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] arg;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [7:0]           mem [MEM_DEPTH];

    assign cmd    = din[9:8];
    assign arg    = din[ADDR_SIZE-1:0];
    assign accept = rx_valid & ~rx_valid_q;
    // A frame arriving during the read slot is dropped, not deferred.
    assign exec   = accept & (state != RD_ISSUE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and busy flag.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (exec && cmd == CMD_RDATA)
                    state_nx = RD_ISSUE;
            end
            RD_ISSUE: begin
                busy     = 1'b1;
                state_nx = TX_HOLD;
            end
            TX_HOLD: begin
                if (exec)
                    state_nx = (cmd == CMD_RDATA) ? RD_ISSUE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Edge detect, pointers, read address capture and tx handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_addr    <= '0;
            dout       <= '0;
            tx_valid   <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (exec) begin
                case (cmd)
                    CMD_WADDR: wr_ptr <= arg;
                    CMD_WDATA: begin
                        if (WR_AUTO_INC != 0)
                            wr_ptr <= wr_ptr + 1'b1;
                    end
                    CMD_RADDR: rd_ptr <= arg;
                    default: begin
                        rd_addr <= rd_ptr;
                        if (RD_AUTO_INC != 0)
                            rd_ptr <= rd_ptr + 1'b1;
                    end
                endcase
            end
            if (state == RD_ISSUE) begin
                dout     <= mem[rd_addr];
                tx_valid <= 1'b1;
            end else if (state == TX_HOLD && exec) begin
                tx_valid <= 1'b0;
            end
        end
    end

    // Storage array; deliberately unreset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (exec && cmd == CMD_WDATA)
            mem[wr_ptr] <= din[7:0];
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: one instance without auto-increment (a)
// and one with both auto-increments (b), driven by the same frame stream.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       tx_valid_a, tx_valid_b;
    logic       busy_a, busy_b;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .MEM_DEPTH(256), .ADDR_SIZE(8),
        .WR_AUTO_INC(0), .RD_AUTO_INC(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_a), .tx_valid(tx_valid_a), .busy(busy_a)
    );

    spi_ram_ctrl #(
        .MEM_DEPTH(256), .ADDR_SIZE(8),
        .WR_AUTO_INC(1), .RD_AUTO_INC(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_b), .tx_valid(tx_valid_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Raise rx_valid with frame f for 'hold' cycles; returns at the
    // negedge just after the accept edge with rx_valid already low.
    task automatic put(input logic [9:0] f, input int hold);
        @(negedge clk);
        din = f;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Issue a read-data command and check the two-cycle handshake.
    task automatic rd(input string tag, input logic [7:0] ea,
                      input logic [7:0] eb);
        put(10'h300, 1);
        chk({tag, " busy_a"}, busy_a, 1);
        chk({tag, " busy_b"}, busy_b, 1);
        chk({tag, " txv_a early"}, tx_valid_a, 0);
        chk({tag, " txv_b early"}, tx_valid_b, 0);
        @(negedge clk);
        chk({tag, " txv_a"}, tx_valid_a, 1);
        chk({tag, " txv_b"}, tx_valid_b, 1);
        chk({tag, " dout_a"}, dout_a, ea);
        chk({tag, " dout_b"}, dout_b, eb);
        chk({tag, " busy_a off"}, busy_a, 0);
    endtask

    initial begin
        logic held_ok;

        // Reset state.
        #12;
        chk("rst dout_a", dout_a, 0);
        chk("rst txv_a", tx_valid_a, 0);
        chk("rst busy_b", busy_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back 0xA5 at 0x3C.
        put(10'h03C, 1);
        put(10'h1A5, 1);
        put(10'h23C, 1);
        rd("wr/rd", 8'hA5, 8'hA5);

        // tx_valid holds while idle, then drops on next accept.
        held_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid_a || !tx_valid_b || dout_a != 8'hA5)
                held_ok = 1'b0;
        end
        chk("hold 50", held_ok, 1);
        put(10'h010, 1);
        chk("drop txv_a", tx_valid_a, 0);
        chk("drop txv_b", tx_valid_b, 0);
        chk("drop dout_a", dout_a, 8'hA5);
        chk("drop dout_b", dout_b, 8'hA5);

        // Held rx_valid writes once; b advances wr_ptr by exactly one.
        put(10'h111, 20);
        put(10'h122, 1);
        put(10'h210, 1);
        rd("held", 8'h22, 8'h11);

        // Back-to-back read from TX_HOLD.
        rd("b2b", 8'h22, 8'h22);

        // Pointer wrap at 0xFF.
        put(10'h0FF, 1);
        put(10'h101, 1);
        put(10'h102, 1);
        put(10'h2FF, 1);
        rd("wrap1", 8'h02, 8'h01);
        rd("wrap2", 8'h02, 8'h02);

        // Async reset while in TX_HOLD.
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid txv_a", tx_valid_a, 0);
        chk("amid txv_b", tx_valid_b, 0);
        chk("amid dout_a", dout_a, 0);
        chk("amid dout_b", dout_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pointers reset to 0; memory kept across reset.
        put(10'h15A, 1);
        rd("ptr rst", 8'h5A, 8'h5A);
        put(10'h2FF, 1);
        rd("mem keep", 8'h02, 8'h01);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
